// File: rtl/fp_normalize_pkg.sv
// fp_normalize_pkg: field layout of the 16-bit adder result word and the
// state encoding shared by the normalizer and its leading-zero counter.
package fp_normalize_pkg;

  // Word layout: [15] sign, [14:10] exponent, [9:0] mantissa (explicit one at bit 9)
  localparam int DATA_W   = 16;
  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int CNT_W    = 4;
  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 10;
  localparam int MAN_HI   = 9;
  localparam int MAN_LO   = 0;

  // Normalizer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Assemble a result word from its three fields
  function automatic logic [DATA_W-1:0] fp_pack(input logic             sign,
                                                input logic [EXP_W-1:0] exp_f,
                                                input logic [MAN_W-1:0] man_f);
    return {sign, exp_f, man_f};
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero count of a 10-bit mantissa; an all-zero input
// reports 10.
module fp_lzc
  import fp_normalize_pkg::*;
(
  input  logic [MAN_W-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // seen[i] is set when any bit at or above position i is one
  logic [MAN_W-1:0] seen;

  genvar gi;
  generate
    for (gi = 0; gi < MAN_W; gi++) begin : g_seen
      assign seen[gi] = |din[MAN_W-1:gi];
    end
  endgenerate

  // Every position that has no one at or above it is a leading zero
  always_comb begin
    cnt = '0;
    for (int i = 0; i < MAN_W; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, ~seen[i]};
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// fp_normalize: post-adder normalizer. Shifts the mantissa left until the
// explicit one reaches bit 9, decrementing the exponent per shift, and
// flushes to zero when the exponent runs out first.
// Build option: FP_NORM_FAST_EN replaces the one-shift-per-cycle loop with a
// single-cycle shift by the leading-zero count (fp_lzc).
module fp_normalize
  import fp_normalize_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              zero_flag,
  output logic              underflow
);

  state_t state_reg, state_next;

  // Working operand while shifting
  logic             sign_reg, sign_next;
  logic [EXP_W-1:0] exp_reg,  exp_next;
  logic [MAN_W-1:0] man_reg,  man_next;
  logic [CNT_W-1:0] cnt_reg,  cnt_next;

  // Result captured on entry to DONE and held until consumed
  logic [DATA_W-1:0] out_data_reg;
  logic [CNT_W-1:0]  shift_cnt_reg;
  logic              zero_flag_reg;
  logic              underflow_reg;

  // Result being produced this cycle (valid when res_load)
  logic              res_load;
  logic [DATA_W-1:0] res_data;
  logic [CNT_W-1:0]  res_cnt;
  logic              res_zero;
  logic              res_uf;
  logic              take_shift;

  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;

  assign in_sign = in_data[SIGN_BIT];
  assign in_exp  = in_data[EXP_HI:EXP_LO];
  assign in_man  = in_data[MAN_HI:MAN_LO];

`ifdef FP_NORM_FAST_EN
  logic [CNT_W-1:0] lz_cnt;

  fp_lzc u_lzc (
    .din (in_man),
    .cnt (lz_cnt)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: accept only in IDLE, leave SHIFT once a result is produced,
  // leave DONE only when downstream takes the result
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = take_shift ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (res_load) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: classify the accepted operand, then step the shift loop
  always_comb begin
    sign_next  = sign_reg;
    exp_next   = exp_reg;
    man_next   = man_reg;
    cnt_next   = cnt_reg;
    res_load   = 1'b0;
    res_data   = '0;
    res_cnt    = '0;
    res_zero   = 1'b0;
    res_uf     = 1'b0;
    take_shift = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          sign_next = in_sign;
          exp_next  = in_exp;
          man_next  = in_man;
          cnt_next  = '0;
          if (in_man == '0) begin
            // Zero mantissa: forced zero, sign dropped
            res_load = 1'b1;
            res_zero = 1'b1;
          end else if (in_man[MAN_HI]) begin
            // Already normalized: pass through untouched
            res_load = 1'b1;
            res_data = in_data;
          end else begin
`ifdef FP_NORM_FAST_EN
            res_load = 1'b1;
            if ({1'b0, lz_cnt} > in_exp) begin
              // Exponent would run out before the one reaches bit 9; the
              // count reports the shifts the loop would have made
              res_zero = 1'b1;
              res_uf   = 1'b1;
              res_cnt  = in_exp[CNT_W-1:0];
            end else begin
              res_data = fp_pack(in_sign, in_exp - {1'b0, lz_cnt}, in_man << lz_cnt);
              res_cnt  = lz_cnt;
            end
`else
            take_shift = 1'b1;
`endif
          end
        end
      end
      ST_SHIFT: begin
        if (exp_reg == '0) begin
          // Exponent exhausted while still denormal: flush
          res_load = 1'b1;
          res_zero = 1'b1;
          res_uf   = 1'b1;
          res_cnt  = cnt_reg;
        end else begin
          man_next = man_reg << 1;
          exp_next = exp_reg - 1'b1;
          cnt_next = cnt_reg + 1'b1;
          // Finish on the same cycle as the shift that normalizes
          if (man_next[MAN_HI]) begin
            res_load = 1'b1;
            res_data = fp_pack(sign_reg, exp_next, man_next);
            res_cnt  = cnt_next;
          end
        end
      end
      default: ;
    endcase
  end

  // Working operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg <= 1'b0;
      exp_reg  <= '0;
      man_reg  <= '0;
      cnt_reg  <= '0;
    end else begin
      sign_reg <= sign_next;
      exp_reg  <= exp_next;
      man_reg  <= man_next;
      cnt_reg  <= cnt_next;
    end
  end

  // Result registers: loaded once per operation, held through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      shift_cnt_reg <= '0;
      zero_flag_reg <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (res_load) begin
      out_data_reg  <= res_data;
      shift_cnt_reg <= res_cnt;
      zero_flag_reg <= res_zero;
      underflow_reg <= res_uf;
    end
  end

  assign out_data  = out_data_reg;
  assign shift_cnt = shift_cnt_reg;
  assign zero_flag = zero_flag_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_fp_normalize.sv
// tb_fp_normalize: directed vector table, random operands against a
// behavioural model, backpressure and reset-abort sequences.
module tb_fp_normalize;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  shift_cnt;
  logic        zero_flag;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  fp_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .shift_cnt (shift_cnt),
    .zero_flag (zero_flag),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic [3:0]  cnt;
    logic        zf;
    logic        uf;
    int          lat;   // iterative-mode latency
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int mode_lat(input int iter_lat);
`ifdef FP_NORM_FAST_EN
    return 1;
`else
    return iter_lat;
`endif
  endfunction

  // Reference: find the leading one, shift it to bit 9 if the exponent allows
  task automatic model(input logic [15:0] d, output logic [15:0] o, output logic [3:0] c,
                       output logic z, output logic u, output int lat);
    int man, e, k, p;
    man = int'(d[9:0]);
    e   = int'(d[14:10]);
    o = 16'h0000; c = 4'd0; z = 1'b0; u = 1'b0; lat = 1;
    if (man == 0) begin
      z = 1'b1;
    end else begin
      p = 0;
      for (int b = 0; b < 10; b++) if (man >= (1 << b)) p = b;
      k = 9 - p;
      if (k == 0) begin
        o = d;
      end else if (k > e) begin
        // e shifts use up the exponent, one more cycle sees it is gone
        z = 1'b1; u = 1'b1; c = 4'(e); lat = e + 2;
      end else begin
        o = {d[15], 5'(e - k), 10'((man * (1 << k)) % 1024)};
        c = 4'(k);
        lat = 1 + k;
      end
    end
  endtask

  // One operation: transfer, measure latency, check result, hold, consume
  task automatic run_op(input logic [15:0] d, input logic [15:0] e_out, input logic [3:0] e_cnt,
                        input logic e_z, input logic e_u, input int e_lat, input int hold,
                        input bit stuff);
    int lat;
    logic [15:0] held;
    lat = 0;
    while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    check("ready_before_xfer", in_ready, 1);
    in_data = d; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("latency", lat, e_lat);
    check("out_data", out_data, e_out);
    check("shift_cnt", shift_cnt, e_cnt);
    check("zero_flag", zero_flag, e_z);
    check("underflow", underflow, e_u);
    held = out_data;
    if (stuff) begin in_valid = 1'b1; in_data = ~d; end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, held);
      check("hold_cnt", shift_cnt, e_cnt);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    $display("op in=%04h out=%04h cnt=%0d zf=%0d uf=%0d lat=%0d hold=%0d", d, held, shift_cnt,
             zero_flag, underflow, lat, hold);
  endtask

  vec_t vecs[11];

  initial begin
    logic [15:0] mo;
    logic [3:0]  mc;
    logic        mz, mu;
    int          ml;
    logic [15:0] rd;

    vecs[0]  = '{16'h3E00, 16'h3E00, 4'd0, 1'b0, 1'b0, 1};
    vecs[1]  = '{16'h3C40, 16'h3200, 4'd3, 1'b0, 1'b0, 4};
    vecs[2]  = '{16'h0801, 16'h0000, 4'd2, 1'b1, 1'b1, 4};
    vecs[3]  = '{16'h8000, 16'h0000, 4'd0, 1'b1, 1'b0, 1};
    vecs[4]  = '{16'hBC40, 16'hB200, 4'd3, 1'b0, 1'b0, 4};
    vecs[5]  = '{16'h0401, 16'h0000, 4'd1, 1'b1, 1'b1, 3};
    vecs[6]  = '{16'h2401, 16'h0200, 4'd9, 1'b0, 1'b0, 10};
    vecs[7]  = '{16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1};
    vecs[8]  = '{16'h7FFF, 16'h7FFF, 4'd0, 1'b0, 1'b0, 1};
    vecs[9]  = '{16'h0001, 16'h0000, 4'd0, 1'b1, 1'b1, 2};
    vecs[10] = '{16'h0500, 16'h0200, 4'd1, 1'b0, 1'b0, 2};

    rst = 1'b1; in_data = 16'h0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_shift_cnt", shift_cnt, 0);
    check("rst_zero_flag", zero_flag, 0);
    check("rst_underflow", underflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Directed table; the 0x3C40 entry also gets the 5-cycle backpressure hold
    foreach (vecs[i]) begin
      run_op(vecs[i].din, vecs[i].dout, vecs[i].cnt, vecs[i].zf, vecs[i].uf,
             mode_lat(vecs[i].lat), (i == 1) ? 5 : 1, (i == 0));
    end

    // Reset during the 2nd SHIFT cycle of 0x3C40 (DONE in the fast build)
    in_data = 16'h3C40; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifndef FP_NORM_FAST_EN
    check("abort_no_valid_c1", out_valid, 0);
`endif
    @(posedge clk); #1;
`ifndef FP_NORM_FAST_EN
    check("abort_no_valid_c2", out_valid, 0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", out_valid, 0);
    end
    $display("op reset-abort of 3c40 done");

    // Reset while a result sits in DONE
    in_data = 16'h3E00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("done_before_rst", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("done_rst_valid", out_valid, 0);
    check("done_rst_data", out_data, 0);
    check("done_rst_in_ready", in_ready, 1);
    $display("op reset in DONE done");

    // Random operands, biased toward small exponents and leading zeros
    for (int n = 0; n < 150; n++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rd[14:10] = 5'($urandom_range(0, 11));
      rd[9:0] = 10'($urandom_range(0, 1023) >> $urandom_range(0, 10));
      model(rd, mo, mc, mz, mu, ml);
      run_op(rd, mo, mc, mz, mu, mode_lat(ml), $urandom_range(0, 2), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
